// File: rtl/pcoeff_result_collector_pkg.sv
// Shared types and widths for the pcoeff result collector.
// The permutation pipeline output uses the same result widths.
package pcoeff_result_collector_pkg;

  localparam int PCOEFF_SUM_IN_WIDTH   = 48;
  localparam int PCOEFF_COUNT_IN_WIDTH = 13;

  typedef enum logic [2:0] {
    IDLE,
    GRAB,
    WAIT,
    ACCUM,
    DONE
  } collector_state_t;

endpackage

// File: rtl/pcoeff_result_collector_accumulator.sv
// Wide sum/count accumulators with zero-extension and sticky carry-out flag.
// Clear has priority over enable; both are single-cycle strobes.
module pcoeff_accumulator
  import pcoeff_result_collector_pkg::*;
#(
  parameter int SUM_WIDTH   = 64,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clr_i,
  input  logic                             en_i,
  input  logic [PCOEFF_SUM_IN_WIDTH-1:0]   sum_i,
  input  logic [PCOEFF_COUNT_IN_WIDTH-1:0] count_i,
  output logic [SUM_WIDTH-1:0]             sum_o,
  output logic [COUNT_WIDTH-1:0]           count_o,
  output logic                             ovf_o
);

  logic [SUM_WIDTH-1:0]   sum_q, sum_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  // One extra bit on each adder captures the carry out of the MSB.
  logic [SUM_WIDTH:0]   sum_add;
  logic [COUNT_WIDTH:0] cnt_add;

  assign sum_add = {1'b0, sum_q} + (SUM_WIDTH+1)'(sum_i);
  assign cnt_add = {1'b0, cnt_q} + (COUNT_WIDTH+1)'(count_i);

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      sum_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      sum_d = sum_add[SUM_WIDTH-1:0];
      cnt_d = cnt_add[COUNT_WIDTH-1:0];
      ovf_d = ovf_q | sum_add[SUM_WIDTH] | cnt_add[COUNT_WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum_o   = sum_q;
  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/pcoeff_result_collector.sv
// Drains per-bot pcoeff results from the pipeline FIFO and totals them per job.
// Totals are offered on a valid/ready handshake and stay readable until the next job.
module pcoeff_result_collector
  import pcoeff_result_collector_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int SUM_WIDTH    = 64,
  parameter int COUNT_WIDTH  = 32,
  parameter int JOB_WIDTH    = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             jobStart,
  input  logic [JOB_WIDTH-1:0]             jobBotCount,
  input  logic                             resultsAvailable,
  output logic                             grabResults,
  input  logic [PCOEFF_SUM_IN_WIDTH-1:0]   pcoeffSum,
  input  logic [PCOEFF_COUNT_IN_WIDTH-1:0] pcoeffCount,
  input  logic                             eccStatus,
  output logic                             busy,
  output logic                             outValid,
  input  logic                             outReady,
  output logic [SUM_WIDTH-1:0]             outSum,
  output logic [COUNT_WIDTH-1:0]           outCount,
  output logic                             outEccError,
  output logic                             outOverflow
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  collector_state_t     state_q, state_d;
  logic [JOB_WIDTH-1:0] remaining_q, remaining_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic                 ecc_q, ecc_d;
  logic                 grab;
  logic                 acc_clr;
  logic                 acc_en;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    lat_d       = lat_q;
    ecc_d       = ecc_q;
    grab        = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (jobStart) begin
          remaining_d = jobBotCount;
          ecc_d       = 1'b0;
          acc_clr     = 1'b1;
          state_d     = (jobBotCount == '0) ? DONE : GRAB;
        end
      end
      GRAB: begin
        if (resultsAvailable) begin
          grab    = 1'b1;
          lat_d   = LAT_W'(READ_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = ACCUM;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ACCUM: begin
        acc_en      = 1'b1;
        remaining_d = remaining_q - JOB_WIDTH'(1);
        state_d     = (remaining_d == '0) ? DONE : GRAB;
      end
      DONE: begin
        if (outReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // ECC errors are only attributed to the job while results are moving.
    if (state_q == GRAB || state_q == WAIT || state_q == ACCUM) begin
      ecc_d = ecc_q | eccStatus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      lat_q       <= '0;
      ecc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      lat_q       <= lat_d;
      ecc_q       <= ecc_d;
    end
  end

  pcoeff_accumulator #(
    .SUM_WIDTH  (SUM_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_acc (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (acc_clr),
    .en_i   (acc_en),
    .sum_i  (pcoeffSum),
    .count_i(pcoeffCount),
    .sum_o  (outSum),
    .count_o(outCount),
    .ovf_o  (outOverflow)
  );

  assign grabResults = grab & ~rst;
  assign busy        = (state_q != IDLE);
  assign outValid    = (state_q == DONE);
  assign outEccError = ecc_q;

endmodule
